// File: rtl/button_press_pkg.sv
// Shared types and constants for the multi-channel push-button detector.
package button_press_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  // Synchroniser flops come out of reset as "released".
  localparam logic SYNC_RST = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_press_chan.sv
// One button channel: 2-FF synchroniser, debounce FSM, press pulse and held level.
// Auto-repeat pulses while held are built only with BUTTON_PRESS_REPEAT_EN.
module button_press_chan
  import button_press_pkg::*;
#(
  parameter int DEBOUNCE      = 4,
  parameter int CNT_W         = 16,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic button_out,
  output logic button_held
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

  // Leaves a visibly named block in the hierarchy if the counters are too narrow.
  if (longint'(max3(DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD)) >= (longint'(1) << CNT_W))
  begin : g_cnt_w_too_small
  end

  logic [1:0] sync_q;
  logic       synced;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{SYNC_RST}};
    else     sync_q <= {sync_q[0], button_in};
  end

  assign synced = sync_q[1];

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             press_d, pulse_d, out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      out_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!synced) begin
          if (DEBOUNCE == 1) begin
            state_d = HELD;
            held_d  = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (synced) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          held_d  = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HELD: begin
        if (synced) begin
          if (DEBOUNCE == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        // A low sample here is a release bounce: back to HELD without a pulse.
        if (!synced) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

`ifdef BUTTON_PRESS_REPEAT_EN
  localparam logic [CNT_W-1:0] RD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP = CNT_W'(REPEAT_PERIOD);

  logic             enter_held, stay_held, rep_fire, rep_first_q;
  logic [CNT_W-1:0] rep_cnt_q;

  assign enter_held = (state_d == HELD) && (state_q != HELD);
  assign stay_held  = (state_d == HELD) && (state_q == HELD);
  // rep_cnt_q counts edges since the last pulse (or since entering HELD).
  assign rep_fire   = stay_held && (rep_cnt_q == (rep_first_q ? RD : RP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (enter_held || rep_fire) begin
      rep_cnt_q   <= ONE;
      rep_first_q <= enter_held;
    end else if (stay_held) begin
      rep_cnt_q   <= rep_cnt_q + ONE;
    end else begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end
  end

  assign pulse_d = press_d | rep_fire;
`else
  assign pulse_d = press_d;
`endif

  assign button_out  = out_q;
  assign button_held = held_q;

endmodule

// File: rtl/button_press_multi.sv
// Multi-channel push-button detector: CHANNELS independent debounced channels.
// Define BUTTON_PRESS_REPEAT_EN to enable auto-repeat pulses while a button is held.
module button_press_multi #(
  parameter int CHANNELS      = 4,
  parameter int DEBOUNCE      = 4,
  parameter int CNT_W         = 16,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] button_out,
  output logic [CHANNELS-1:0] button_held
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    button_press_chan #(
      .DEBOUNCE     (DEBOUNCE),
      .CNT_W        (CNT_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .button_in  (button_in[g]),
      .button_out (button_out[g]),
      .button_held(button_held[g])
    );
  end

endmodule

// File: tb/tb_button_press_multi.sv
// Bench for button_press_multi: run-length behavioural model compared every cycle,
// plus directed scenarios with hand-computed pulse counts and latencies.
module tb_button_press_multi;

  localparam int CH = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef BUTTON_PRESS_REPEAT_EN
  localparam int HOLD40_PULSES = 5;
`else
  localparam int HOLD40_PULSES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] button_in = '0;
  logic [CH-1:0] button_out, button_held;

  button_press_multi #(
    .CHANNELS(CH), .DEBOUNCE(DB), .CNT_W(16), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .button_in(button_in),
    .button_out(button_out), .button_held(button_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: the input seen by the debouncer lags two edges; the held level flips
  // once DB consecutive samples disagree with it.
  bit            d1[CH] = '{default: 1'b1};
  bit            d2[CH] = '{default: 1'b1};
  bit            prev_s[CH] = '{default: 1'b1};
  bit            m_held[CH] = '{default: 1'b0};
  int            lo_run[CH] = '{default: 0};
  int            hi_run[CH] = '{default: 0};
  int            t_held[CH] = '{default: 0};
  logic [CH-1:0] exp_out = '0;
  logic [CH-1:0] exp_held = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        d1[c] <= 1'b1; d2[c] <= 1'b1; prev_s[c] <= 1'b1; m_held[c] <= 1'b0;
        lo_run[c] <= 0; hi_run[c] <= 0; t_held[c] <= 0;
      end
      exp_out  <= '0;
      exp_held <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        automatic bit s    = d2[c];
        automatic int lo   = s ? 0 : ((lo_run[c] < 1000) ? lo_run[c] + 1 : 1000);
        automatic int hi   = s ? ((hi_run[c] < 1000) ? hi_run[c] + 1 : 1000) : 0;
        automatic bit h    = m_held[c];
        automatic bit was  = m_held[c] && !prev_s[c];
        automatic int t    = t_held[c];
        automatic bit p    = 1'b0;
        if (!h && lo >= DB) begin
          h = 1'b1; p = 1'b1; t = 0;
        end else if (h && hi >= DB) begin
          h = 1'b0;
        end else if (h && !s) begin
          if (was) begin
            t = t + 1;
`ifdef BUTTON_PRESS_REPEAT_EN
            if (t >= RD && ((t - RD) % RP) == 0) p = 1'b1;
`endif
          end else begin
            t = 0;
          end
        end
        d2[c] <= d1[c];
        d1[c] <= button_in[c];
        prev_s[c] <= s;
        lo_run[c] <= lo;
        hi_run[c] <= hi;
        m_held[c] <= h;
        t_held[c] <= t;
        exp_out[c]  <= p;
        exp_held[c] <= h;
      end
    end
  end

  int pulse_cnt[CH]  = '{default: 0};
  int held_cnt[CH]   = '{default: 0};
  int last_pulse[CH] = '{default: 0};

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      check($sformatf("out[%0d]", c), int'(button_out[c]), int'(exp_out[c]));
      check($sformatf("held[%0d]", c), int'(button_held[c]), int'(exp_held[c]));
      if (button_out[c]) begin
        pulse_cnt[c]++;
        last_pulse[c] = cyc;
      end
      if (button_held[c]) held_cnt[c]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int p0[CH];
  int h0[CH];
  int dc;

  task automatic snap();
    for (int c = 0; c < CH; c++) begin
      p0[c] = pulse_cnt[c];
      h0[c] = held_cnt[c];
    end
  endtask

  initial begin
    // Reset with all buttons pressed; release reset with them still pressed.
    tick(3);
    check("reset_out", int'(button_out), 0);
    check("reset_held", int'(button_held), 0);
    snap();
    rst = 1'b0;
    dc  = cyc;
    tick(12);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("post_rst_pulses[%0d]", c), pulse_cnt[c] - p0[c], 1);
      check($sformatf("post_rst_lat[%0d]", c), last_pulse[c] - dc, DB + 2);
    end
    button_in = '1;
    tick(12);

    // Clean 12-cycle press on channel 0.
    snap();
    button_in[0] = 1'b0;
    tick(12);
    button_in[0] = 1'b1;
    tick(12);
    check("ch0_pulses", pulse_cnt[0] - p0[0], 1);
    check("ch0_held_cycles", held_cnt[0] - h0[0], 12);

    // 3-cycle bounce on channel 1 is rejected.
    snap();
    button_in[1] = 1'b0;
    tick(3);
    button_in[1] = 1'b1;
    tick(10);
    check("ch1_bounce_pulses", pulse_cnt[1] - p0[1], 0);
    check("ch1_bounce_held", held_cnt[1] - h0[1], 0);

    // Channel 2 release bounce: one pulse, held continuous.
    snap();
    button_in[2] = 1'b0;
    tick(10);
    button_in[2] = 1'b1;
    tick(2);
    button_in[2] = 1'b0;
    tick(10);
    button_in[2] = 1'b1;
    tick(12);
    check("ch2_rel_bounce_pulses", pulse_cnt[2] - p0[2], 1);
    check("ch2_rel_bounce_held", held_cnt[2] - h0[2], 22);

    // Channels 0 and 3 pressed together.
    snap();
    dc = cyc;
    button_in[0] = 1'b0;
    button_in[3] = 1'b0;
    tick(8);
    button_in = '1;
    tick(12);
    check("ch03_same_cycle", last_pulse[0], last_pulse[3]);
    check("ch0_press_lat", last_pulse[0] - dc, DB + 2);
    check("ch3_pulses", pulse_cnt[3] - p0[3], 1);

    // Reset during channel 2 PRESS_WAIT discards the pending debounce.
    snap();
    button_in[2] = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    dc  = cyc;
    tick(14);
    button_in[2] = 1'b1;
    tick(12);
    check("ch2_rst_pulses", pulse_cnt[2] - p0[2], 1);
    check("ch2_rst_lat", last_pulse[2] - dc, DB + 2);

    // 40-cycle hold on channel 0.
    snap();
    button_in[0] = 1'b0;
    tick(40);
    button_in[0] = 1'b1;
    tick(12);
    check("ch0_hold40_pulses", pulse_cnt[0] - p0[0], HOLD40_PULSES);

    // Random toggling with occasional resets, checked against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 15) == 0) button_in[c] = ~button_in[c];
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick(1);
    end
    button_in = '1;
    tick(12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
